// File: rtl/hv_seg_streamer.sv
// Streams one HV_DIM-bit hypervector out as DIMS_PER_CC-bit segments in ascending index
// order, dropping the segments flagged in a per-vector skip mask.
module hv_seg_streamer #(
    parameter int HV_DIM      = 4096,
    parameter int DIMS_PER_CC = 1024,
    parameter int NUM_SEGS    = HV_DIM / DIMS_PER_CC,
    parameter int IDX_W       = $clog2(NUM_SEGS)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   hv_valid,
    output logic                   hv_ready,
    input  logic [HV_DIM-1:0]      hv_in,
    input  logic [NUM_SEGS-1:0]    seg_skip,
    input  logic                   abort,
    output logic                   seg_valid,
    input  logic                   seg_ready,
    output logic [DIMS_PER_CC-1:0] seg_data,
    output logic [IDX_W-1:0]       seg_idx,
    output logic                   seg_last,
    output logic                   skip_all,
    output logic                   busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Lowest unskipped index at or above 'start'; MSB of the result flags that one exists.
    function automatic logic [IDX_W:0] f_find_zero(input logic [NUM_SEGS-1:0] mask,
                                                   input int start);
        logic [IDX_W:0] res;
        res = {(IDX_W+1){1'b0}};
        for (int k = NUM_SEGS - 1; k >= 0; k--) begin
            if ((k >= start) && !mask[k]) begin
                res = {1'b1, IDX_W'(k)};
            end
        end
        return res;
    endfunction

    state_t                 r_state;
    logic [HV_DIM-1:0]      r_hold;
    logic [NUM_SEGS-1:0]    r_mask;
    logic                   r_seg_valid;
    logic [DIMS_PER_CC-1:0] r_seg_data;
    logic [IDX_W-1:0]       r_seg_idx;
    logic                   r_seg_last;
    logic                   r_skip_all;
    logic                   r_busy;

    state_t                 w_nxt_state;
    logic [HV_DIM-1:0]      w_nxt_hold;
    logic [NUM_SEGS-1:0]    w_nxt_mask;
    logic                   w_nxt_valid;
    logic [DIMS_PER_CC-1:0] w_nxt_data;
    logic [IDX_W-1:0]       w_nxt_idx;
    logic                   w_nxt_last;
    logic                   w_nxt_skip_all;
    logic [IDX_W:0]         w_find;
    logic [IDX_W:0]         w_after;
    logic                   w_accept;
    logic                   w_xfer;

    assign hv_ready  = (r_state == ST_IDLE);
    assign w_accept  = hv_valid & hv_ready;
    assign w_xfer    = r_seg_valid & seg_ready;

    assign seg_valid = r_seg_valid;
    assign seg_data  = r_seg_data;
    assign seg_idx   = r_seg_idx;
    assign seg_last  = r_seg_last;
    assign skip_all  = r_skip_all;
    assign busy      = r_busy;

    // Next-state, beat selection and capture logic; abort overrides any handshake.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_hold     = r_hold;
        w_nxt_mask     = r_mask;
        w_nxt_valid    = r_seg_valid;
        w_nxt_data     = r_seg_data;
        w_nxt_idx      = r_seg_idx;
        w_nxt_last     = r_seg_last;
        w_nxt_skip_all = 1'b0;
        w_find         = {(IDX_W+1){1'b0}};
        w_after        = {(IDX_W+1){1'b0}};
        if (abort) begin
            w_nxt_state = ST_IDLE;
            w_nxt_valid = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_nxt_hold = hv_in;
                        w_nxt_mask = seg_skip;
                        w_find     = f_find_zero(seg_skip, 0);
                        if (w_find[IDX_W]) begin
                            w_after     = f_find_zero(seg_skip, int'(w_find[IDX_W-1:0]) + 1);
                            w_nxt_state = ST_SEND;
                            w_nxt_valid = 1'b1;
                            w_nxt_idx   = w_find[IDX_W-1:0];
                            w_nxt_data  = hv_in[int'(w_find[IDX_W-1:0]) * DIMS_PER_CC +: DIMS_PER_CC];
                            w_nxt_last  = ~w_after[IDX_W];
                        end else begin
                            w_nxt_skip_all = 1'b1;
                        end
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (r_seg_last) begin
                            w_nxt_state = ST_IDLE;
                            w_nxt_valid = 1'b0;
                        end else begin
                            // A non-last beat guarantees a further unskipped index exists.
                            w_find     = f_find_zero(r_mask, int'(r_seg_idx) + 1);
                            w_after    = f_find_zero(r_mask, int'(w_find[IDX_W-1:0]) + 1);
                            w_nxt_idx  = w_find[IDX_W-1:0];
                            w_nxt_data = r_hold[int'(w_find[IDX_W-1:0]) * DIMS_PER_CC +: DIMS_PER_CC];
                            w_nxt_last = ~w_after[IDX_W];
                        end
                    end else begin
                        w_nxt_state = ST_SEND;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_valid = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_hold      <= {HV_DIM{1'b0}};
            r_mask      <= {NUM_SEGS{1'b0}};
            r_seg_valid <= 1'b0;
            r_seg_data  <= {DIMS_PER_CC{1'b0}};
            r_seg_idx   <= {IDX_W{1'b0}};
            r_seg_last  <= 1'b0;
            r_skip_all  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_hold      <= w_nxt_hold;
            r_mask      <= w_nxt_mask;
            r_seg_valid <= w_nxt_valid;
            r_seg_data  <= w_nxt_data;
            r_seg_idx   <= w_nxt_idx;
            r_seg_last  <= w_nxt_last;
            r_skip_all  <= w_nxt_skip_all;
            r_busy      <= (w_nxt_state == ST_SEND);
        end
    end

endmodule

// File: tb/tb_hv_seg_streamer.sv
// Directed self-checking bench for hv_seg_streamer: streaming, backpressure, skipping,
// all-skipped pulse, abort and mid-stream reset.
module tb_hv_seg_streamer;

    localparam int HV_DIM = 4096;
    localparam int D      = 1024;
    localparam int NS     = 4;
    localparam int IW     = 2;

    logic          clk       = 1'b0;
    logic          nrst      = 1'b0;
    logic          hv_valid  = 1'b0;
    logic          abort     = 1'b0;
    logic          seg_ready = 1'b0;
    logic [HV_DIM-1:0] hv_in = {HV_DIM{1'b0}};
    logic [NS-1:0] seg_skip  = {NS{1'b0}};
    logic          hv_ready;
    logic          seg_valid;
    logic [D-1:0]  seg_data;
    logic [IW-1:0] seg_idx;
    logic          seg_last;
    logic          skip_all;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    hv_seg_streamer #(.HV_DIM(HV_DIM), .DIMS_PER_CC(D)) dut (
        .clk(clk), .nrst(nrst), .hv_valid(hv_valid), .hv_ready(hv_ready),
        .hv_in(hv_in), .seg_skip(seg_skip), .abort(abort),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_data(seg_data),
        .seg_idx(seg_idx), .seg_last(seg_last), .skip_all(skip_all), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (low 256 bits)", tag, obs[255:0], exp[255:0]);
        end
    endtask

    function automatic logic [D-1:0] seg_pat(input int v);
        logic [3:0] n;
        n = 4'(v);
        return {256{n}};
    endfunction

    function automatic logic [HV_DIM-1:0] hv_pat(input int base);
        return {seg_pat(base + 3), seg_pat(base + 2), seg_pat(base + 1), seg_pat(base)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input int k, input logic [D-1:0] data, input logic last);
        check_val({tag, ".valid"}, D'(seg_valid), D'(1'b1));
        check_val({tag, ".idx"},   D'(seg_idx),   D'(k));
        check_val({tag, ".data"},  seg_data,      data);
        check_val({tag, ".last"},  D'(seg_last),  D'(last));
        check_val({tag, ".ready"}, D'(hv_ready),  D'(1'b0));
        check_val({tag, ".busy"},  D'(busy),      D'(1'b1));
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".valid"}, D'(seg_valid), D'(1'b0));
        check_val({tag, ".ready"}, D'(hv_ready),  D'(1'b1));
        check_val({tag, ".busy"},  D'(busy),      D'(1'b0));
    endtask

    // Accept a vector, then scramble the inputs to prove they are ignored while streaming.
    task automatic send_vec(input logic [HV_DIM-1:0] hv, input logic [NS-1:0] skip);
        hv_valid = 1'b1;
        hv_in    = hv;
        seg_skip = skip;
        tick();
        hv_valid = 1'b0;
        hv_in    = ~hv;
        seg_skip = 4'b1111;
    endtask

    task automatic run_stream(input string tag, input int base, input logic [NS-1:0] skip,
                              input int exp_last, input int stall_idx, input int stall_n);
        seg_ready = 1'b1;
        send_vec(hv_pat(base), skip);
        for (int k = 0; k < NS; k++) begin
            if (!skip[k]) begin
                if (k == stall_idx) begin
                    seg_ready = 1'b0;
                    for (int s = 0; s < stall_n; s++) begin
                        check_beat($sformatf("%s.stall%0d", tag, s), k, seg_pat(base + k), k == exp_last);
                        tick();
                    end
                    seg_ready = 1'b1;
                end
                check_beat($sformatf("%s.b%0d", tag, k), k, seg_pat(base + k), k == exp_last);
                tick();
            end
        end
        check_idle({tag, ".end"});
    endtask

    initial begin
        #1;
        check_idle("rst");
        check_val("rst.data",  seg_data,      {D{1'b0}});
        check_val("rst.idx",   D'(seg_idx),   D'(0));
        check_val("rst.last",  D'(seg_last),  D'(0));
        check_val("rst.skip",  D'(skip_all),  D'(0));
        tick();
        tick();
        nrst = 1'b1;
        tick();

        run_stream("full", 0, 4'b0000, 3, -1, 0);
        run_stream("bp",   0, 4'b0000, 3,  1, 3);
        run_stream("sk5",  4, 4'b0101, 3, -1, 0);
        run_stream("sk7",  8, 4'b0111, 3, -1, 0);

        // All-skipped vector followed immediately by a real one.
        seg_ready = 1'b1;
        hv_valid  = 1'b1;
        hv_in     = hv_pat(0);
        seg_skip  = 4'b1111;
        tick();
        check_val("all.pulse", D'(skip_all), D'(1'b1));
        check_idle("all");
        hv_in    = hv_pat(8);
        seg_skip = 4'b0000;
        tick();
        hv_valid = 1'b0;
        check_val("all.pulse_end", D'(skip_all), D'(1'b0));
        for (int k = 0; k < NS; k++) begin
            check_beat($sformatf("b2b.b%0d", k), k, seg_pat(8 + k), k == 3);
            tick();
        end
        check_idle("b2b.end");

        // Abort while idx 2 is stalled.
        seg_ready = 1'b1;
        send_vec(hv_pat(0), 4'b0000);
        check_beat("ab.b0", 0, seg_pat(0), 1'b0);
        tick();
        check_beat("ab.b1", 1, seg_pat(1), 1'b0);
        tick();
        seg_ready = 1'b0;
        check_beat("ab.b2", 2, seg_pat(2), 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("ab.after");
        check_val("ab.noskip", D'(skip_all), D'(1'b0));
        seg_ready = 1'b1;
        tick();
        check_idle("ab.after2");

        // Abort in IDLE blocks a simultaneous handshake.
        abort    = 1'b1;
        hv_valid = 1'b1;
        hv_in    = hv_pat(4);
        seg_skip = 4'b0000;
        tick();
        abort    = 1'b0;
        hv_valid = 1'b0;
        check_idle("ab.idle");
        tick();
        check_idle("ab.idle2");
        run_stream("post_ab", 8, 4'b0000, 3, -1, 0);

        // Asynchronous reset in the middle of a stream.
        seg_ready = 1'b1;
        send_vec(hv_pat(4), 4'b0000);
        check_beat("mr.b0", 0, seg_pat(4), 1'b0);
        tick();
        #2;
        nrst = 1'b0;
        #1;
        check_idle("mr");
        check_val("mr.data", seg_data,    {D{1'b0}});
        check_val("mr.idx",  D'(seg_idx), D'(0));
        tick();
        nrst = 1'b1;
        tick();
        check_idle("mr.rel");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
